wired_nor_requester: RTL and testbench

// - Drive side of the active-low wired-NOR request lines: each channel asserts its line when local logic requests,
//   and the central NOR combining all lines produces the shared busy/request term.
// - Per channel: request -> line asserted -> wait grant -> ack -> minimum hold -> release -> wait grant drop.
// - Sits between local bus-cycle logic and the backplane request/grant pairs; guards against a lost grant with a timeout.

---
 rtl/wired_nor_pkg.sv | 23 ++
 rtl/wired_nor_req_channel.sv | 98 +++++++++
 rtl/wired_nor_requester.sv | 54 +++++
 tb/tb_wired_nor_requester.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/wired_nor_pkg.sv
// Shared types and defaults for the wired-NOR request line drivers.
package wired_nor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam int         DEF_CHANNELS       = 3;
  localparam logic [2:0] DEF_POLARITY_MASK  = 3'b111;
  localparam int         DEF_TIMEOUT_CYCLES = 255;
  localparam int         DEF_HOLD_CYCLES    = 2;

  // One counter serves both the grant wait and the hold phase, so size it for the larger.
  function automatic int cnt_width(input int timeout_cycles, input int hold_cycles);
    int m;
    m = (timeout_cycles > hold_cycles) ? timeout_cycles : hold_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/wired_nor_req_channel.sv
// One request/grant pair: request FSM, shared wait/hold counter and line polarity.
module wired_nor_req_channel
  import wired_nor_pkg::*;
#(
  parameter int   TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int   HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter logic POLARITY       = 1'b1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   req_i,
  input  logic   gnt_i,
  output logic   line_o,
  output logic   line_oe_o,
  output logic   ack_o,
  output logic   timeout_o,
  output logic   busy_d_o,
  output state_e state_o
);

  localparam int             CW        = cnt_width(TIMEOUT_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            line_q, oe_q, ack_q, to_q;
  logic            ack_d, to_d, active_d;
  logic            gnt_act;

  assign gnt_act = gnt_i ^ POLARITY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = WAIT_GNT;
          cnt_d   = '0;
        end
      end
      // Same-cycle priority: grant beats abort beats timeout.
      WAIT_GNT: begin
        if (gnt_act) begin
          state_d = HOLD;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end else if (!req_i) begin
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = RELEASE;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      RELEASE: begin
        if (!gnt_act) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign active_d = (state_d == WAIT_GNT) || (state_d == HOLD);
  assign busy_d_o = (state_d != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= POLARITY;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= active_d ^ POLARITY;
      oe_q    <= active_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
    end
  end

  assign line_o    = line_q;
  assign line_oe_o = oe_q;
  assign ack_o     = ack_q;
  assign timeout_o = to_q;
  assign state_o   = state_q;

endmodule

// File: rtl/wired_nor_requester.sv
// Drives a bank of wired-NOR request lines, one independent channel per request/grant pair.
module wired_nor_requester
  import wired_nor_pkg::*;
#(
  parameter int                  CHANNELS       = DEF_CHANNELS,
  parameter logic [CHANNELS-1:0] POLARITY_MASK  = CHANNELS'(DEF_POLARITY_MASK),
  parameter int                  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int                  HOLD_CYCLES    = DEF_HOLD_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   req_i,
  input  logic [CHANNELS-1:0]   gnt_i,
  output logic [CHANNELS-1:0]   line_o,
  output logic [CHANNELS-1:0]   line_oe_o,
  output logic [CHANNELS-1:0]   ack_o,
  output logic [CHANNELS-1:0]   timeout_o,
  output logic                  busy_o,
  output logic [2*CHANNELS-1:0] dbg_state_o
);

  logic [CHANNELS-1:0] busy_d;
  logic                busy_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e st;
    wired_nor_req_channel #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .POLARITY       (POLARITY_MASK[i])
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .req_i     (req_i[i]),
      .gnt_i     (gnt_i[i]),
      .line_o    (line_o[i]),
      .line_oe_o (line_oe_o[i]),
      .ack_o     (ack_o[i]),
      .timeout_o (timeout_o[i]),
      .busy_d_o  (busy_d[i]),
      .state_o   (st)
    );
    assign dbg_state_o[2*i +: 2] = st;
  end

  // Registered from the channels' next states so busy lines up with their registered outputs.
  always_ff @(posedge clock) begin
    if (reset) busy_q <= 1'b0;
    else       busy_q <= |busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_wired_nor_requester.sv
// Bench for wired_nor_requester: two configurations driven in lockstep, checked against a cycle model.
module tb_wired_nor_requester;

  localparam logic [2:0] MASK0 = 3'b111;
  localparam logic [2:0] MASK1 = 3'b010;
  localparam int TO0 = 4, HO0 = 2;
  localparam int TO1 = 6, HO1 = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] req0, gnt0, req1, gnt1;
  logic [2:0] line0, oe0, ack0, to0, line1, oe1, ack1, to1;
  logic       busy0, busy1;
  logic [5:0] dbg0, dbg1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  wired_nor_requester #(
    .CHANNELS(3), .POLARITY_MASK(MASK0), .TIMEOUT_CYCLES(TO0), .HOLD_CYCLES(HO0)
  ) dut0 (
    .clock(clock), .reset(reset), .req_i(req0), .gnt_i(gnt0),
    .line_o(line0), .line_oe_o(oe0), .ack_o(ack0), .timeout_o(to0),
    .busy_o(busy0), .dbg_state_o(dbg0)
  );

  wired_nor_requester #(
    .CHANNELS(3), .POLARITY_MASK(MASK1), .TIMEOUT_CYCLES(TO1), .HOLD_CYCLES(HO1)
  ) dut1 (
    .clock(clock), .reset(reset), .req_i(req1), .gnt_i(gnt1),
    .line_o(line1), .line_oe_o(oe1), .ack_o(ack1), .timeout_o(to1),
    .busy_o(busy1), .dbg_state_o(dbg1)
  );

  // Reference model: per channel a phase (0 idle, 1 requesting, 2 holding, 3 releasing)
  // plus how many cycles have been spent in the current phase.
  int  ph   [2][3];
  int  spent[2][3];
  bit  m_ack[2][3];
  bit  m_to [2][3];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(input int d, input bit rst, input logic [2:0] r, input logic [2:0] ga);
    int lim_to, lim_ho;
    lim_to = (d == 0) ? TO0 : TO1;
    lim_ho = (d == 0) ? HO0 : HO1;
    for (int c = 0; c < 3; c++) begin
      m_ack[d][c] = 1'b0;
      m_to[d][c]  = 1'b0;
      if (rst) begin
        ph[d][c]    = 0;
        spent[d][c] = 0;
      end else begin
        case (ph[d][c])
          0: if (r[c]) begin ph[d][c] = 1; spent[d][c] = 0; end
          1: begin
            if (ga[c]) begin
              ph[d][c] = 2; spent[d][c] = 0; m_ack[d][c] = 1'b1;
            end else if (!r[c]) begin
              ph[d][c] = 0;
            end else if (spent[d][c] + 1 >= lim_to) begin
              ph[d][c] = 0; m_to[d][c] = 1'b1;
            end else begin
              spent[d][c]++;
            end
          end
          2: begin
            spent[d][c]++;
            if (spent[d][c] >= lim_ho) ph[d][c] = 3;
          end
          default: if (!ga[c]) ph[d][c] = 0;
        endcase
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [2:0] e_line, e_oe, e_ack, e_to, mask;
      logic       e_busy;
      mask   = (d == 0) ? MASK0 : MASK1;
      e_busy = 1'b0;
      for (int c = 0; c < 3; c++) begin
        e_oe[c]  = (ph[d][c] == 1) || (ph[d][c] == 2);
        e_ack[c] = m_ack[d][c];
        e_to[c]  = m_to[d][c];
        if (ph[d][c] != 0) e_busy = 1'b1;
      end
      e_line = e_oe ^ mask;
      check_eq($sformatf("d%0d line_o", d),    8'((d == 0) ? line0 : line1), 8'(e_line));
      check_eq($sformatf("d%0d line_oe_o", d), 8'((d == 0) ? oe0 : oe1),     8'(e_oe));
      check_eq($sformatf("d%0d ack_o", d),     8'((d == 0) ? ack0 : ack1),   8'(e_ack));
      check_eq($sformatf("d%0d timeout_o", d), 8'((d == 0) ? to0 : to1),     8'(e_to));
      check_eq($sformatf("d%0d busy_o", d),    8'((d == 0) ? busy0 : busy1), 8'(e_busy));
    end
  endtask

  // Grants are given in active sense and converted to each bus's physical polarity.
  task automatic step(input bit rst, input logic [2:0] r, input logic [2:0] ga);
    reset = rst;
    req0  = r;
    req1  = r;
    gnt0  = ga ^ MASK0;
    gnt1  = ga ^ MASK1;
    model_step(0, rst, r, ga);
    model_step(1, rst, r, ga);
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    logic [2:0] rr, gg;
    reset = 1'b1;
    req0 = '0; req1 = '0;
    gnt0 = MASK0; gnt1 = MASK1;

    // reset held with all requests high, then the first free cycle
    repeat (3) step(1'b1, 3'b111, 3'b000);
    step(1'b0, 3'b111, 3'b000);
    step(1'b1, 3'b000, 3'b000);

    // ch0 normal: request at 0, grant at 4
    for (int k = 0; k < 10; k++)
      step(1'b0, (k < 5) ? 3'b001 : 3'b000, (k >= 4 && k < 7) ? 3'b001 : 3'b000);

    // ch1 timeout (abort on the longer-timeout instance)
    for (int k = 0; k < 8; k++)
      step(1'b0, (k < 5) ? 3'b010 : 3'b000, 3'b000);

    // ch1 grant on the last timeout cycle
    for (int k = 0; k < 8; k++)
      step(1'b0, (k < 5) ? 3'b010 : 3'b000, (k == 4) ? 3'b010 : 3'b000);

    // ch2 request dropped while waiting
    for (int k = 0; k < 6; k++)
      step(1'b0, (k < 3) ? 3'b100 : 3'b000, 3'b000);

    // ch2 reset during HOLD
    step(1'b0, 3'b100, 3'b000);
    step(1'b0, 3'b100, 3'b100);
    step(1'b1, 3'b000, 3'b100);
    step(1'b0, 3'b000, 3'b000);
    step(1'b0, 3'b000, 3'b000);

    // randomized levels with occasional reset
    rr = '0;
    gg = '0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 5) == 0) rr[c] = ~rr[c];
        if ($urandom_range(0, 3) == 0) gg[c] = ~gg[c];
      end
      step($urandom_range(0, 99) == 0, rr, gg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
